// File: rtl/secuenciador_alu.sv
// Sequences one ALU operation: serial load of A, B and opcode, timed launch and
// capture, then delivery of the 2*ANCHO result as high/low blocks over valid/ready.
module secuenciador_alu #(
  parameter int ANCHO   = 8,
  parameter int LAT_ALU = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ANCHO-1:0]   dato_in,
  input  logic               cargar,
  output logic [ANCHO-1:0]   alu_a,
  output logic [ANCHO-1:0]   alu_b,
  output logic [3:0]         alu_op,
  output logic               alu_start,
  input  logic [2*ANCHO-1:0] alu_resultado,
  input  logic [3:0]         alu_flags,
  output logic [3:0]         flags_out,
  output logic               selector_bloque,
  output logic [ANCHO-1:0]   dato_out,
  output logic               dato_valido,
  input  logic               dato_listo,
  output logic               ocupado,
  output logic [2:0]         estado
);

  localparam logic [2:0] ESPERA_A    = 3'd0;
  localparam logic [2:0] ESPERA_B    = 3'd1;
  localparam logic [2:0] ESPERA_OP   = 3'd2;
  localparam logic [2:0] EJECUTAR    = 3'd3;
  localparam logic [2:0] SALIDA_ALTO = 3'd4;
  localparam logic [2:0] SALIDA_BAJO = 3'd5;

  localparam logic [3:0] LAT_C = 4'(LAT_ALU);

  logic [3:0]       cnt_q;
  logic [ANCHO-1:0] res_bajo_q;

  // Every output is a flop loaded alongside the state transition, so the
  // handshake outputs are valid in the very first cycle of each SALIDA state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado          <= ESPERA_A;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_op          <= '0;
      alu_start       <= 1'b0;
      flags_out       <= '0;
      selector_bloque <= 1'b0;
      dato_out        <= '0;
      dato_valido     <= 1'b0;
      ocupado         <= 1'b0;
      cnt_q           <= '0;
      res_bajo_q      <= '0;
    end else begin
      alu_start <= 1'b0;
      case (estado)
        ESPERA_A: if (cargar) begin
          alu_a  <= dato_in;
          estado <= ESPERA_B;
        end
        ESPERA_B: if (cargar) begin
          alu_b  <= dato_in;
          estado <= ESPERA_OP;
        end
        ESPERA_OP: if (cargar) begin
          alu_op    <= dato_in[3:0];
          alu_start <= 1'b1;
          cnt_q     <= '0;
          ocupado   <= 1'b1;
          estado    <= EJECUTAR;
        end
        EJECUTAR: begin
          // Result is valid in the cycle where the counter reaches LAT_ALU.
          if (cnt_q == LAT_C) begin
            cnt_q           <= '0;
            res_bajo_q      <= alu_resultado[ANCHO-1:0];
            flags_out       <= alu_flags;
            dato_out        <= alu_resultado[2*ANCHO-1:ANCHO];
            selector_bloque <= 1'b0;
            dato_valido     <= 1'b1;
            estado          <= SALIDA_ALTO;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SALIDA_ALTO: if (dato_listo) begin
          dato_out        <= res_bajo_q;
          selector_bloque <= 1'b1;
          estado          <= SALIDA_BAJO;
        end
        SALIDA_BAJO: if (dato_listo) begin
          dato_out        <= '0;
          selector_bloque <= 1'b0;
          dato_valido     <= 1'b0;
          ocupado         <= 1'b0;
          estado          <= ESPERA_A;
        end
        default: begin
          dato_out        <= '0;
          selector_bloque <= 1'b0;
          dato_valido     <= 1'b0;
          ocupado         <= 1'b0;
          estado          <= ESPERA_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_alu.sv
// Drives two sequencers (LAT_ALU 1 and 3) with directed and random traffic and
// compares every cycle against a transaction-level queue model.
module tb_secuenciador_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference ALU behaviour: product for opcode 3, a mixing function otherwise.
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    if (op == 4'h3) return 16'(a) * 16'(b);
    return {a ^ {4'h0, op}, b};
  endfunction

  function automatic logic [3:0] flg_f(input logic [15:0] r, input logic [7:0] a,
                                       input logic [3:0] op);
    return {r == 16'h0, r[15], a[7], op[0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst_n = 1'b0, cargar = 1'b0, dato_listo = 1'b1;
    logic [7:0]  dato_in = 8'h0;
    logic [7:0]  alu_a, alu_b, dato_out;
    logic [3:0]  alu_op, alu_flags, flags_out;
    logic        alu_start, selector_bloque, dato_valido, ocupado;
    logic [2:0]  estado;
    logic [15:0] alu_resultado;

    secuenciador_alu #(.ANCHO(8), .LAT_ALU(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .dato_in(dato_in), .cargar(cargar),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_resultado(alu_resultado), .alu_flags(alu_flags), .flags_out(flags_out),
      .selector_bloque(selector_bloque), .dato_out(dato_out), .dato_valido(dato_valido),
      .dato_listo(dato_listo), .ocupado(ocupado), .estado(estado)
    );

    // ALU environment: result is correct only LAT cycles after the start pulse.
    int          since = 100;
    logic [15:0] junk_r = 16'h0;
    logic [3:0]  junk_f = 4'h0;
    initial forever begin
      @(posedge clk);
      since  <= !rst_n ? 100 : alu_start ? 1 : (since < 100 ? since + 1 : 100);
      junk_r <= 16'($urandom);
      junk_f <= 4'($urandom);
    end
    assign alu_resultado = (since == LAT) ? alu_f(alu_a, alu_b, alu_op) : junk_r;
    assign alu_flags = (since == LAT) ?
                       flg_f(alu_f(alu_a, alu_b, alu_op), alu_a, alu_op) : junk_f;

    // Transaction model: loads fill operands, an op load schedules a capture
    // LAT+1 edges later, and the capture queues the two result bytes.
    int          cyc = 0, nld = 0, cap_at = -1;
    logic [7:0]  ma = 8'h0, mb = 8'h0;
    logic [3:0]  mop = 4'h0, mflags = 4'h0;
    logic [15:0] mr;
    bit          mexec = 1'b0, mstart = 1'b0;
    logic [7:0]  q [$];
    initial forever begin
      @(posedge clk);
      cyc++;
      mstart = 1'b0;
      if (!rst_n) begin
        nld = 0; ma = 8'h0; mb = 8'h0; mop = 4'h0; mflags = 4'h0;
        mexec = 1'b0; q.delete();
      end else if (mexec) begin
        if (cyc == cap_at) begin
          mr = alu_f(ma, mb, mop);
          q.push_back(mr[15:8]);
          q.push_back(mr[7:0]);
          mflags = flg_f(mr, ma, mop);
          mexec = 1'b0;
        end
      end else if (q.size() != 0) begin
        if (dato_listo) void'(q.pop_front());
      end else if (cargar) begin
        case (nld)
          0: ma = dato_in;
          1: mb = dato_in;
          default: begin
            mop = dato_in[3:0]; mexec = 1'b1; mstart = 1'b1; cap_at = cyc + LAT + 1;
          end
        endcase
        nld = (nld + 1) % 3;
      end
    end

    initial forever begin
      int est;
      @(negedge clk);
      if (cyc > 0) begin
        est = mexec ? 3 : (q.size() == 2) ? 4 : (q.size() == 1) ? 5 : nld;
        chk($sformatf("L%0d alu_a", LAT), 32'(alu_a), 32'(ma));
        chk($sformatf("L%0d alu_b", LAT), 32'(alu_b), 32'(mb));
        chk($sformatf("L%0d alu_op", LAT), 32'(alu_op), 32'(mop));
        chk($sformatf("L%0d alu_start", LAT), 32'(alu_start), 32'(mstart));
        chk($sformatf("L%0d flags_out", LAT), 32'(flags_out), 32'(mflags));
        chk($sformatf("L%0d dato_valido", LAT), 32'(dato_valido), 32'(q.size() != 0));
        chk($sformatf("L%0d dato_out", LAT), 32'(dato_out), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk($sformatf("L%0d selector", LAT), 32'(selector_bloque), 32'(q.size() == 1));
        chk($sformatf("L%0d ocupado", LAT), 32'(ocupado), 32'(mexec || q.size() != 0));
        chk($sformatf("L%0d estado", LAT), 32'(estado), 32'(est));
      end
    end

    task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      cargar = 1'b1; dato_in = a;  @(negedge clk);
      dato_in = b;                 @(negedge clk);
      dato_in = op;                @(negedge clk);
      cargar = 1'b0; dato_in = 8'h0;
    endtask

    // Called in the first EJECUTAR cycle; n counts cycles from the op-load edge.
    task automatic wait_valid(output int n, output int nexec);
      n = 1; nexec = 0;
      while (!dato_valido && n < 60) begin
        if (estado == 3'd3) nexec++;
        @(negedge clk);
        n++;
      end
      chk($sformatf("L%0d valid_timeout", LAT), 32'(dato_valido), 32'h1);
    endtask

    initial begin
      int n, nexec;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk($sformatf("L%0d rst_estado", LAT), 32'(estado), 32'h0);
      chk($sformatf("L%0d rst_valido", LAT), 32'(dato_valido), 32'h0);

      // nominal, back-to-back delivery
      dato_listo = 1'b1;
      load3(8'h12, 8'h34, 8'h03);
      chk($sformatf("L%0d nom_start", LAT), 32'(alu_start), 32'h1);
      wait_valid(n, nexec);
      chk($sformatf("L%0d nom_latency", LAT), 32'(n), 32'(LAT + 2));
      chk($sformatf("L%0d nom_exec_len", LAT), 32'(nexec), 32'(LAT + 1));
      chk($sformatf("L%0d nom_hi", LAT), 32'(dato_out), 32'h03);
      chk($sformatf("L%0d nom_hi_sel", LAT), 32'(selector_bloque), 32'h0);
      chk($sformatf("L%0d nom_flags", LAT), 32'(flags_out), 32'h1);
      @(negedge clk);
      chk($sformatf("L%0d nom_lo", LAT), 32'(dato_out), 32'hA8);
      chk($sformatf("L%0d nom_lo_sel", LAT), 32'(selector_bloque), 32'h1);
      @(negedge clk);
      chk($sformatf("L%0d nom_idle", LAT), 32'(estado), 32'h0);

      // backpressure on the high block
      dato_listo = 1'b0;
      load3(8'h12, 8'h34, 8'h03);
      wait_valid(n, nexec);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("L%0d bp_hi", LAT), 32'({dato_valido, dato_out}), 32'h103);
        @(negedge clk);
      end
      dato_listo = 1'b1;
      @(negedge clk);
      chk($sformatf("L%0d bp_lo", LAT), 32'({selector_bloque, dato_out}), 32'h1A8);
      @(negedge clk);

      // strobes while busy are dropped
      dato_listo = 1'b0;
      load3(8'h12, 8'h34, 8'h03);
      cargar = 1'b1; dato_in = 8'hFF; @(negedge clk);
      cargar = 1'b0; dato_in = 8'h00;
      wait_valid(n, nexec);
      dato_listo = 1'b1; @(negedge clk);
      dato_listo = 1'b0; cargar = 1'b1; dato_in = 8'hFF; @(negedge clk);
      cargar = 1'b0; dato_in = 8'h00;
      chk($sformatf("L%0d ign_bajo", LAT), 32'(estado), 32'h5);
      dato_listo = 1'b1; @(negedge clk);
      chk($sformatf("L%0d ign_ops", LAT), 32'({alu_a, alu_b, alu_op}), 32'h12343);
      chk($sformatf("L%0d ign_idle", LAT), 32'(estado), 32'h0);

      // reset while presenting the high block
      dato_listo = 1'b0;
      load3(8'h56, 8'h78, 8'h03);
      wait_valid(n, nexec);
      rst_n = 1'b0; @(negedge clk);
      rst_n = 1'b1;
      chk($sformatf("L%0d mrst_outs", LAT),
          32'({alu_a, alu_b, alu_op, flags_out, dato_out}), 32'h0);
      chk($sformatf("L%0d mrst_ctl", LAT),
          32'({estado, ocupado, dato_valido, selector_bloque, alu_start}), 32'h0);
      dato_listo = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk($sformatf("L%0d mrst_novalid", LAT), 32'(dato_valido), 32'h0);
      end

      // opcode upper nibble ignored
      load3(8'h07, 8'h09, 8'hA5);
      chk($sformatf("L%0d op_mask", LAT), 32'(alu_op), 32'h5);
      repeat (LAT + 5) @(negedge clk);

      // random traffic with random backpressure, stray strobes and resets
      for (int i = 0; i < 1500; i++) begin
        cargar     = ($urandom_range(0, 2) == 0);
        dato_in    = 8'($urandom);
        dato_listo = 1'($urandom_range(0, 1));
        rst_n      = ($urandom_range(0, 79) != 0);
        @(negedge clk);
      end
      rst_n = 1'b1; cargar = 1'b0; dato_listo = 1'b1;
      repeat (10) @(negedge clk);
      done[g] = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(done[0] && done[1]) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("bench_timeout", 32'(done[0] && done[1]), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
